// File: rtl/axi_pkg.sv
// Shared AXI3 encodings: response codes, burst types and the SRAM responder state encoding.
package axi_pkg;

  typedef enum logic [1:0] {
    RespOkay   = 2'b00,
    RespExokay = 2'b01,
    RespSlverr = 2'b10,
    RespDecerr = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    BurstFixed = 2'b00,
    BurstIncr  = 2'b01,
    BurstWrap  = 2'b10,
    BurstRsvd  = 2'b11
  } burst_e;

  typedef enum logic [2:0] {
    StIdle,
    StRdIssue,
    StRdBeat,
    StWrData,
    StWrResp
  } state_e;

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational AXI3 next-beat byte address.
// Ports: addr_i current byte address, len_i/size_i/burst_i burst attributes,
//        next_o address of the following beat.
module axi_burst_addr
  import axi_pkg::*;
(
  input  logic [31:0] addr_i,
  input  logic [3:0]  len_i,
  input  logic [2:0]  size_i,
  input  logic [1:0]  burst_i,
  output logic [31:0] next_o
);

  logic [31:0] step;
  logic [31:0] incr;
  logic [31:0] wrap_mask;

  assign step      = 32'd1 << size_i;
  assign incr      = addr_i + step;
  // Wrap block is (len+1) beats; low bits roll over inside the aligned block.
  assign wrap_mask = (({28'd0, len_i} + 32'd1) << size_i) - 32'd1;

  always_comb begin
    next_o = incr;
    unique case (burst_i)
      BurstFixed: next_o = addr_i;
      BurstWrap:  next_o = (addr_i & ~wrap_mask) | (incr & wrap_mask);
      default:    next_o = incr;  // INCR and reserved
    endcase
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 responder for a synchronous single-port SRAM, one transaction at a time.
// Ports: AXI3 AR/R/AW/W/B channels (lock/cache/prot/wid ignored) and an SRAM
//        port (ram_en, ram_wen byte strobes, ram_addr word address, ram_wdata,
//        ram_rdata valid one cycle after ram_en). Reads and writes alternate
//        priority when both are requested in the same cycle.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_W    = 14,
  parameter logic [31:0] BASE_ADDR = 32'h1FC0_0000,
  parameter int unsigned ID_W      = 4
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [ID_W-1:0]   arid,
  input  logic [31:0]       araddr,
  input  logic [3:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic [1:0]        arlock,
  input  logic [3:0]        arcache,
  input  logic [2:0]        arprot,
  input  logic              arvalid,
  output logic              arready,
  output logic [ID_W-1:0]   rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic [ID_W-1:0]   awid,
  input  logic [31:0]       awaddr,
  input  logic [3:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic [1:0]        awlock,
  input  logic [3:0]        awcache,
  input  logic [2:0]        awprot,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ID_W-1:0]   wid,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  output logic              ram_en,
  output logic [3:0]        ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam logic [31:0] SramBytes = 32'd4 << ADDR_W;

  state_e          state_q, state_d;
  logic            prio_q, prio_d;  // 0: read wins a tie, 1: write wins
  logic [ID_W-1:0] id_q, id_d;
  logic [31:0]     addr_q, addr_d;
  logic [3:0]      len_q, len_d;
  logic [2:0]      size_q, size_d;
  logic [1:0]      burst_q, burst_d;
  logic [3:0]      beat_q, beat_d;
  logic            err_q, err_d;
  logic            miss_q, miss_d;
  logic            rd_first_q, rd_first_d;
  logic [31:0]     rdata_q, rdata_d;

  logic [31:0] next_addr;
  logic [31:0] offset;
  logic        hit;
  logic        last_beat;
  logic [31:0] rd_word;
  logic        unused_ok;

  assign unused_ok = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

  axi_burst_addr u_burst_addr (
    .addr_i  (addr_q),
    .len_i   (len_q),
    .size_i  (size_q),
    .burst_i (burst_q),
    .next_o  (next_addr)
  );

  assign offset    = addr_q - BASE_ADDR;
  assign hit       = (addr_q >= BASE_ADDR) && (offset < SramBytes);
  assign last_beat = (beat_q == len_q);
  // SRAM data is live only in the first RD_BEAT cycle; afterwards replay the captured copy.
  assign rd_word   = rd_first_q ? (hit ? ram_rdata : 32'd0) : rdata_q;

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    id_d       = id_q;
    addr_d     = addr_q;
    len_d      = len_q;
    size_d     = size_q;
    burst_d    = burst_q;
    beat_d     = beat_q;
    err_d      = err_q;
    miss_d     = miss_q;
    rd_first_d = 1'b0;
    rdata_d    = rdata_q;
    arready    = 1'b0;
    awready    = 1'b0;
    wready     = 1'b0;
    ram_en     = 1'b0;
    ram_wen    = 4'd0;
    ram_addr   = addr_q[ADDR_W+1:2];
    ram_wdata  = wdata;

    unique case (state_q)
      StIdle: begin
        arready = arvalid & (~awvalid | ~prio_q);
        awready = awvalid & (~arvalid | prio_q);
        if (arready) begin
          id_d    = arid;
          addr_d  = araddr;
          len_d   = arlen;
          size_d  = arsize;
          burst_d = arburst;
          beat_d  = 4'd0;
          err_d   = (arburst == BurstRsvd);
          miss_d  = 1'b0;
          prio_d  = 1'b1;
          state_d = StRdIssue;
        end else if (awready) begin
          id_d    = awid;
          addr_d  = awaddr;
          len_d   = awlen;
          size_d  = awsize;
          burst_d = awburst;
          beat_d  = 4'd0;
          err_d   = (awburst == BurstRsvd);
          miss_d  = 1'b0;
          prio_d  = 1'b0;
          state_d = StWrData;
        end
      end
      StRdIssue: begin
        ram_en     = hit;
        rd_first_d = 1'b1;
        state_d    = StRdBeat;
      end
      StRdBeat: begin
        rdata_d = rd_word;
        if (rready) begin
          if (last_beat) begin
            state_d = StIdle;
          end else begin
            addr_d  = next_addr;
            beat_d  = beat_q + 4'd1;
            state_d = StRdIssue;
          end
        end
      end
      StWrData: begin
        wready = 1'b1;
        if (wvalid) begin
          ram_en  = hit;
          ram_wen = hit ? wstrb : 4'd0;
          if (wlast != last_beat) err_d = 1'b1;
          if (!hit) miss_d = 1'b1;
          if (last_beat) begin
            state_d = StWrResp;
          end else begin
            addr_d = next_addr;
            beat_d = beat_q + 4'd1;
          end
        end
      end
      StWrResp: begin
        if (bready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= StIdle;
      prio_q     <= 1'b0;
      id_q       <= '0;
      addr_q     <= 32'd0;
      len_q      <= 4'd0;
      size_q     <= 3'd0;
      burst_q    <= 2'd0;
      beat_q     <= 4'd0;
      err_q      <= 1'b0;
      miss_q     <= 1'b0;
      rd_first_q <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      id_q       <= id_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      beat_q     <= beat_d;
      err_q      <= err_d;
      miss_q     <= miss_d;
      rd_first_q <= rd_first_d;
      rdata_q    <= rdata_d;
    end
  end

  assign rvalid = (state_q == StRdBeat);
  assign rlast  = rvalid & last_beat;
  assign rdata  = rd_word;
  assign rid    = id_q;
  assign bvalid = (state_q == StWrResp);
  assign bid    = id_q;

  always_comb begin
    rresp = RespOkay;
    if (rvalid) begin
      if (!hit)       rresp = RespDecerr;
      else if (err_q) rresp = RespSlverr;
    end
    bresp = RespOkay;
    if (bvalid) begin
      if (miss_q)     bresp = RespDecerr;
      else if (err_q) bresp = RespSlverr;
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
module tb_axi_sram_slave;

  localparam logic [31:0] Base   = 32'h1FC0_0000;
  localparam logic [1:0]  Okay   = 2'b00;
  localparam logic [1:0]  Slverr = 2'b10;
  localparam logic [1:0]  Decerr = 2'b11;
  localparam logic [1:0]  Incr   = 2'b01;
  localparam logic [1:0]  Wrap   = 2'b10;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [3:0]  arid = '0, awid = '0, wid = '0, rid, bid;
  logic [31:0] araddr = '0, awaddr = '0, wdata = '0, rdata, ram_wdata, ram_rdata;
  logic [3:0]  arlen = '0, awlen = '0, wstrb = '0, ram_wen, arcache = '0, awcache = '0;
  logic [2:0]  arsize = 3'd2, awsize = 3'd2, arprot = '0, awprot = '0;
  logic [1:0]  arburst = '0, awburst = '0, arlock = '0, awlock = '0, rresp, bresp;
  logic        arvalid = 0, arready, rlast, rvalid, rready = 0;
  logic        awvalid = 0, awready, wlast = 0, wvalid = 0, wready, bvalid, bready = 0;
  logic        ram_en;
  logic [13:0] ram_addr;

  logic [31:0] mem [0:16383];
  int          en_cnt = 0;
  int          vectors = 0;
  int          miscompares = 0;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } rexp_t;
  rexp_t rq[$];

  always #5 aclk = ~aclk;

  axi_sram_slave dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // SRAM model: preload then serve one access per enabled cycle.
  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = (i < 64) ? i : 32'd0;
    mem[17] = 32'h5566_7788;
    ram_rdata = '0;
    forever begin
      @(posedge aclk);
      if (ram_en) begin
        en_cnt++;
        ram_rdata <= mem[ram_addr];
        for (int b = 0; b < 4; b++)
          if (ram_wen[b]) mem[ram_addr][b*8 +: 8] = ram_wdata[b*8 +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_r(input logic [31:0] d, input logic [1:0] rs, input logic l,
                        input logic [3:0] id);
    rexp_t e;
    e.data = d; e.resp = rs; e.last = l; e.id = id;
    rq.push_back(e);
  endtask

  task automatic wait_ar_hs();
    int n = 0;
    #1;
    while (!arready && n < 30) begin @(negedge aclk); #1; n++; end
    chk("ar_handshake", arready, 1);
    @(posedge aclk); #1 arvalid = 0;
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                         input logic [1:0] burst);
    @(negedge aclk);
    arid = id; araddr = a; arlen = len; arburst = burst; arvalid = 1;
    wait_ar_hs();
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                         input logic [1:0] burst);
    int n = 0;
    @(negedge aclk);
    awid = id; awaddr = a; awlen = len; awburst = burst; awvalid = 1;
    #1;
    while (!awready && n < 30) begin @(negedge aclk); #1; n++; end
    chk("aw_handshake", awready, 1);
    @(posedge aclk); #1 awvalid = 0;
  endtask

  task automatic wr_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
    int n = 0;
    @(negedge aclk);
    wdata = d; wstrb = s; wlast = l; wvalid = 1;
    #1;
    while (!wready && n < 30) begin @(negedge aclk); #1; n++; end
    chk("w_handshake", wready, 1);
    @(posedge aclk); #1 wvalid = 0; wlast = 0;
  endtask

  task automatic recv_b(input logic [1:0] rs, input logic [3:0] id);
    int n = 0;
    @(negedge aclk);
    while (!bvalid && n < 30) begin @(negedge aclk); n++; end
    chk("b_valid", bvalid, 1);
    chk("bresp", bresp, rs);
    chk("bid", bid, id);
    bready = 1;
    @(posedge aclk); #1 bready = 0;
  endtask

  task automatic recv_r(input int nbeats, input int stall_beat);
    rexp_t e;
    for (int b = 0; b < nbeats; b++) begin
      int n = 0;
      @(negedge aclk);
      while (!rvalid && n < 30) begin @(negedge aclk); n++; end
      chk("r_valid", rvalid, 1);
      e = rq.pop_front();
      chk("rdata", rdata, e.data);
      chk("rresp", rresp, e.resp);
      chk("rlast", rlast, e.last);
      chk("rid", rid, e.id);
      if (b == stall_beat) begin
        repeat (5) begin
          @(negedge aclk);
          chk("stall_rvalid", rvalid, 1);
          chk("stall_rdata", rdata, e.data);
        end
      end
      rready = 1;
      @(posedge aclk); #1 rready = 0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int en_before;
    repeat (3) @(negedge aclk);
    aresetn = 1;
    @(negedge aclk);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_wready", wready, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rid", rid, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_bid", bid, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_ram_wen", ram_wen, 0);

    // Simultaneous AR/AW from reset: read wins, with a mid-burst stall.
    arid = 4'd2; araddr = Base; arlen = 3; arburst = Incr; arvalid = 1;
    awid = 4'd7; awaddr = Base + 32'h80; awlen = 0; awburst = Incr; awvalid = 1;
    #1;
    chk("tie1_arready", arready, 1);
    chk("tie1_awready", awready, 0);
    for (int i = 0; i < 4; i++) push_r(i, Okay, i == 3, 4'd2);
    @(posedge aclk); #1 arvalid = 0;
    recv_r(4, 1);
    // Second tie: write now has priority.
    @(negedge aclk);
    arid = 4'd3; araddr = Base + 32'h20; arlen = 0; arvalid = 1;
    #1;
    chk("tie2_awready", awready, 1);
    chk("tie2_arready", arready, 0);
    @(posedge aclk); #1 awvalid = 0;
    wr_beat(32'hDEAD_BEEF, 4'hF, 1);
    recv_b(Okay, 4'd7);
    chk("tie_mem32", mem[32], 32'hDEAD_BEEF);
    push_r(32'd8, Okay, 1, 4'd3);
    @(negedge aclk);
    wait_ar_hs();
    recv_r(1, -1);

    // INCR read.
    for (int i = 0; i < 4; i++) push_r(4 + i, Okay, i == 3, 4'd5);
    send_ar(4'd5, Base + 32'h10, 3, Incr);
    recv_r(4, -1);

    // WRAP read.
    push_r(6, Okay, 0, 4'd1); push_r(7, Okay, 0, 4'd1);
    push_r(4, Okay, 0, 4'd1); push_r(5, Okay, 1, 4'd1);
    send_ar(4'd1, Base + 32'h18, 3, Wrap);
    recv_r(4, -1);

    // INCR write with partial strobe on the second beat.
    send_aw(4'd9, Base + 32'h40, 1, Incr);
    wr_beat(32'hAABB_CCDD, 4'b1111, 0);
    wr_beat(32'h1122_3344, 4'b0011, 1);
    recv_b(Okay, 4'd9);
    chk("wr_mem16", mem[16], 32'hAABB_CCDD);
    chk("wr_mem17", mem[17], 32'h5566_3344);

    // Decode miss: no SRAM access.
    en_before = en_cnt;
    push_r(0, Decerr, 1, 4'd1);
    send_ar(4'd1, 32'h0, 0, Incr);
    recv_r(1, -1);
    chk("miss_no_ram_en", en_cnt, en_before);

    // Early wlast: every beat still written, SLVERR.
    send_aw(4'd4, Base + 32'h100, 2, Incr);
    wr_beat(32'h0101_0101, 4'hF, 1);
    wr_beat(32'h0202_0202, 4'hF, 0);
    wr_beat(32'h0303_0303, 4'hF, 1);
    recv_b(Slverr, 4'd4);
    chk("wl_mem64", mem[64], 32'h0101_0101);
    chk("wl_mem65", mem[65], 32'h0202_0202);
    chk("wl_mem66", mem[66], 32'h0303_0303);

    // Reset during RD_BEAT aborts the burst.
    send_ar(4'd6, Base + 32'h10, 3, Incr);
    begin
      int n = 0;
      @(negedge aclk);
      while (!rvalid && n < 30) begin @(negedge aclk); n++; end
      chk("pre_reset_rvalid", rvalid, 1);
    end
    #1 aresetn = 0;
    #1;
    chk("mid_rst_rvalid", rvalid, 0);
    chk("mid_rst_rlast", rlast, 0);
    chk("mid_rst_ram_en", ram_en, 0);
    chk("mid_rst_rdata", rdata, 0);
    chk("mid_rst_rid", rid, 0);
    rq.delete();
    repeat (2) @(negedge aclk);
    aresetn = 1;
    push_r(4, Okay, 1, 4'd9);
    send_ar(4'd9, Base + 32'h10, 0, Incr);
    recv_r(1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
